// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: memory op encodings,
// FSM states, register-file bus widths and small decode helpers.
package lsu_pkg;

    localparam int          REG_DATA_W    = 32;
    localparam int          REG_ADDR_W    = 5;
    localparam logic        RST_ENABLE    = 1'b1;
    localparam logic        WRT_DISABLE   = 1'b0;
    localparam logic [31:0] ZERO_REG_DATA = 32'h0000_0000;
    localparam logic [4:0]  ZERO_REG_ADDR = 5'd0;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_SW  = 3'b011,
        OP_LBU = 3'b100,
        OP_LHU = 3'b101,
        OP_SB  = 3'b110,
        OP_SH  = 3'b111
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } access_size_e;

    // Access width implied by an op; the encoding bits do not map to it directly
    function automatic access_size_e op_size(input mem_op_e op);
        access_size_e sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
            default:              sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic op_is_store(input mem_op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Halfwords need an even address, words need a word-aligned address
    function automatic logic op_misaligned(input mem_op_e op, input logic [1:0] off);
        logic bad;
        case (op_size(op))
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte-select and replicated write data for the
// request side, lane selection and sign/zero extension for returned loads.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  req_op_i,
    input  logic [1:0]  req_off_i,
    input  logic [31:0] store_data_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    input  logic [2:0]  ld_op_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    mem_op_e     reqOp;
    mem_op_e     ldOp;
    logic [7:0]  ldByte;
    logic [15:0] ldHalf;

    assign reqOp = mem_op_e'(req_op_i);
    assign ldOp  = mem_op_e'(ld_op_i);

    // Lane mask shifted to the byte offset and store data replicated across lanes
    always_comb begin
        sel_o   = 4'b1111;
        wdata_o = store_data_i;
        case (op_size(reqOp))
            SZ_BYTE: begin
                sel_o   = 4'b0001 << req_off_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            SZ_HALF: begin
                sel_o   = 4'b0011 << req_off_i;
                wdata_o = {2{store_data_i[15:0]}};
            end
            default: begin
                sel_o   = 4'b1111;
                wdata_o = store_data_i;
            end
        endcase
    end

    // Pick the addressed lane out of the read word and extend it to 32 bits
    always_comb begin
        ldByte    = 8'h00;
        ldHalf    = 16'h0000;
        ld_data_o = rdata_i;
        case (ld_off_i)
            2'b00:   ldByte = rdata_i[7:0];
            2'b01:   ldByte = rdata_i[15:8];
            2'b10:   ldByte = rdata_i[23:16];
            default: ldByte = rdata_i[31:24];
        endcase
        ldHalf = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (ldOp)
            OP_LB:   ld_data_o = {{24{ldByte[7]}}, ldByte};
            OP_LBU:  ld_data_o = {24'h000000, ldByte};
            OP_LH:   ld_data_o = {{16{ldHalf[15]}}, ldHalf};
            OP_LHU:  ld_data_o = {16'h0000, ldHalf};
            default: ld_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: one outstanding req/ack bus transaction per
// memory instruction, pipeline stall while pending, zero-latency pass-through
// for everything else.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i_LSU,
    input  logic                  rst_i_LSU,
    input  logic                  Mem_Req_i_LSU,
    input  logic [2:0]            Mem_Op_i_LSU,
    input  logic [31:0]           Mem_Addr_i_LSU,
    input  logic [REG_DATA_W-1:0] Store_Data_i_LSU,
    input  logic [REG_DATA_W-1:0] Wt_Data_i_LSU,
    input  logic [REG_ADDR_W-1:0] Wt_Addr_i_LSU,
    input  logic                  Wt_Enable_i_LSU,
    output logic                  Bus_Req_o_LSU,
    output logic                  Bus_We_o_LSU,
    output logic [3:0]            Bus_Sel_o_LSU,
    output logic [31:0]           Bus_Addr_o_LSU,
    output logic [31:0]           Bus_Wdata_o_LSU,
    input  logic                  Bus_Ack_i_LSU,
    input  logic [31:0]           Bus_Rdata_i_LSU,
    input  logic                  Bus_Err_i_LSU,
    output logic [REG_DATA_W-1:0] Wt_Data_o_LSU,
    output logic [REG_ADDR_W-1:0] Wt_Addr_o_LSU,
    output logic                  Wt_Enable_o_LSU,
    output logic                  Stall_Req_o_LSU,
    output logic                  Exc_Misalign_o_LSU,
    output logic                  Exc_BusErr_o_LSU
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            op_q, op_d;
    logic [1:0]            off_q, off_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  wen_q, wen_d;
    logic                  we_q, we_d;
    logic [3:0]            sel_q, sel_d;
    logic [29:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           ldata_q, ldata_d;
    logic                  err_q, err_d;

    logic [3:0]            reqSel;
    logic [31:0]           reqWdata;
    logic [31:0]           alignedLoad;
    mem_op_e               reqOp;

    assign reqOp = mem_op_e'(Mem_Op_i_LSU);

    lsu_align u_align (
        .req_op_i     (Mem_Op_i_LSU),
        .req_off_i    (Mem_Addr_i_LSU[1:0]),
        .store_data_i (Store_Data_i_LSU),
        .sel_o        (reqSel),
        .wdata_o      (reqWdata),
        .ld_op_i      (op_q),
        .ld_off_i     (off_q),
        .rdata_i      (Bus_Rdata_i_LSU),
        .ld_data_o    (alignedLoad)
    );

    // State and captured-request registers; reset clears everything so a late ack is harmless
    always_ff @(posedge clk_i_LSU) begin
        if (rst_i_LSU == RST_ENABLE) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            off_q   <= '0;
            rd_q    <= '0;
            wen_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ldata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            off_q   <= off_d;
            rd_q    <= rd_d;
            wen_q   <= wen_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ldata_q <= ldata_d;
            err_q   <= err_d;
        end
    end

    // Next-state and outputs; while reset is held every output stays at its idle value
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        off_d   = off_q;
        rd_d    = rd_q;
        wen_d   = wen_q;
        we_d    = we_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ldata_d = ldata_q;
        err_d   = err_q;

        Bus_Req_o_LSU      = 1'b0;
        Bus_We_o_LSU       = 1'b0;
        Bus_Sel_o_LSU      = 4'b0000;
        Bus_Addr_o_LSU     = 32'h0000_0000;
        Bus_Wdata_o_LSU    = 32'h0000_0000;
        Wt_Data_o_LSU      = ZERO_REG_DATA;
        Wt_Addr_o_LSU      = ZERO_REG_ADDR;
        Wt_Enable_o_LSU    = WRT_DISABLE;
        Stall_Req_o_LSU    = 1'b0;
        Exc_Misalign_o_LSU = 1'b0;
        Exc_BusErr_o_LSU   = 1'b0;

        if (rst_i_LSU != RST_ENABLE) begin
            case (state_q)
                ST_IDLE: begin
                    Wt_Data_o_LSU   = Wt_Data_i_LSU;
                    Wt_Addr_o_LSU   = Wt_Addr_i_LSU;
                    Wt_Enable_o_LSU = Wt_Enable_i_LSU;
                    if (Mem_Req_i_LSU) begin
                        Wt_Enable_o_LSU = WRT_DISABLE;
                        if (op_misaligned(reqOp, Mem_Addr_i_LSU[1:0])) begin
                            Exc_Misalign_o_LSU = 1'b1;
                        end else begin
                            Stall_Req_o_LSU = 1'b1;
                            op_d    = Mem_Op_i_LSU;
                            off_d   = Mem_Addr_i_LSU[1:0];
                            rd_d    = Wt_Addr_i_LSU;
                            wen_d   = Wt_Enable_i_LSU;
                            we_d    = op_is_store(reqOp);
                            sel_d   = reqSel;
                            addr_d  = Mem_Addr_i_LSU[31:2];
                            wdata_d = reqWdata;
                            ldata_d = '0;
                            err_d   = 1'b0;
                            cnt_d   = '0;
                            state_d = ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    Bus_Req_o_LSU   = 1'b1;
                    Bus_We_o_LSU    = we_q;
                    Bus_Sel_o_LSU   = sel_q;
                    Bus_Addr_o_LSU  = {addr_q, 2'b00};
                    Bus_Wdata_o_LSU = wdata_q;
                    Stall_Req_o_LSU = 1'b1;
                    Wt_Addr_o_LSU   = rd_q;
                    cnt_d           = cnt_q + CNT_W'(1);
                    if (Bus_Ack_i_LSU) begin
                        err_d = Bus_Err_i_LSU;
                        if (!Bus_Err_i_LSU && !we_q) begin
                            ldata_d = alignedLoad;
                        end
                        state_d = ST_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    Wt_Data_o_LSU    = ldata_q;
                    Wt_Addr_o_LSU    = rd_q;
                    Wt_Enable_o_LSU  = wen_q && !we_q && !err_q;
                    Exc_BusErr_o_LSU = err_q;
                    state_d          = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule
